// File: rtl/redmule_pkg.sv
// redmule_pkg: shared RedMulE package, TCDM splitter subset.
//   TCDM_SPLIT_DW / TCDM_SPLIT_MP / TCDM_SPLIT_NW : default wide width, port count, narrow width
//   TCDM_SPLIT_OUTST                               : default outstanding-read bound / FIFO depth
//   tcdm_split_narrow_t                            : one narrow port data word
package redmule_pkg;

  localparam int unsigned TCDM_SPLIT_DW    = 128;
  localparam int unsigned TCDM_SPLIT_MP    = 4;
  localparam int unsigned TCDM_SPLIT_NW    = TCDM_SPLIT_DW / TCDM_SPLIT_MP;
  localparam int unsigned TCDM_SPLIT_OUTST = 2;

  typedef logic [TCDM_SPLIT_NW-1:0] tcdm_split_narrow_t;

endpackage

// File: rtl/redmule_tcdm_rsp_fifo.sv
// redmule_tcdm_rsp_fifo: per-port read-response buffer of the TCDM splitter.
// Ports:
//   clk_i, rst_i (async, active-high), clear_i (sync clear)
//   push_i, data_i  : write one narrow word (ignored when full unless popping)
//   pop_i           : drop the head (ignored when empty)
//   data_o          : current head word
//   empty_o, full_o : occupancy flags
module redmule_tcdm_rsp_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(Depth));
  assign data_o  = mem_q[rd_ptr_q];

  // When full, a simultaneous pop frees the head slot, which is exactly the slot written.
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: contents are only observed while non-empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && full_o && !pop_i));
`endif

endmodule

// File: rtl/redmule_tcdm_splitter.sv
// redmule_tcdm_splitter: splits one wide HCI-style RedMulE request onto MP narrow TCDM ports,
// tracks partial grants, realigns per-port read responses into one wide response, and bounds
// outstanding wide reads to OUTST so the per-port response FIFOs cannot overflow.
// Ports:
//   clk_i, rst_i (async, active-high), clear_i (sync soft clear, same effect as reset)
//   req_i/gnt_o, add_i, wen_i (1 = read), be_i, data_i : wide request side
//   r_data_o, r_valid_o                                : wide response (no backpressure)
//   tcdm_req_o/tcdm_gnt_i, tcdm_add_o, tcdm_wen_o,
//   tcdm_be_o, tcdm_data_o                             : narrow request side, port 0 in LSBs
//   tcdm_r_data_i, tcdm_r_valid_i                      : narrow responses, per-port timing
//   busy_o                                             : partial grant held or read outstanding
//   stall_cycles_o                                     : only with REDMULE_TCDM_SPLITTER_PERF_EN,
//                                                        saturating count of req_i & ~gnt_o
module redmule_tcdm_splitter
  import redmule_pkg::*;
#(
  parameter int unsigned DW    = TCDM_SPLIT_DW,
  parameter int unsigned MP    = TCDM_SPLIT_MP,
  parameter int unsigned AW    = 32,
  parameter int unsigned OUTST = TCDM_SPLIT_OUTST
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   req_i,
  output logic                   gnt_o,
  input  logic [AW-1:0]          add_i,
  input  logic                   wen_i,
  input  logic [DW/8-1:0]        be_i,
  input  logic [DW-1:0]          data_i,
  output logic [DW-1:0]          r_data_o,
  output logic                   r_valid_o,
  output logic [MP-1:0]          tcdm_req_o,
  input  logic [MP-1:0]          tcdm_gnt_i,
  output logic [MP*AW-1:0]       tcdm_add_o,
  output logic [MP-1:0]          tcdm_wen_o,
  output logic [DW/8-1:0]        tcdm_be_o,
  output logic [DW-1:0]          tcdm_data_o,
  input  logic [DW-1:0]          tcdm_r_data_i,
  input  logic [MP-1:0]          tcdm_r_valid_i,
`ifdef REDMULE_TCDM_SPLITTER_PERF_EN
  output logic [31:0]            stall_cycles_o,
`endif
  output logic                   busy_o
);

  localparam int unsigned NW = DW / MP;
  localparam int unsigned NB = NW / 8;
  localparam int unsigned CW = $clog2(OUTST + 1);

  logic [MP-1:0] granted_q, granted_d;
  logic [MP-1:0] hit;
  logic [MP-1:0] fifo_empty, fifo_full;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] heads;
  logic          req_eff, stall, issue, rsp_ok;

  // Reset and clear mask the request so every handshake output reads 0 while they are held.
  assign req_eff = req_i & ~rst_i & ~clear_i;
  // A read may only start splitting when a response slot is free in every port FIFO.
  assign stall   = req_eff & wen_i & (cnt_q == CW'(OUTST));
  assign issue   = req_eff & ~stall;

  assign tcdm_req_o = {MP{issue}} & ~granted_q;
  assign hit        = tcdm_req_o & tcdm_gnt_i;
  assign gnt_o      = issue & (&(granted_q | hit));

  assign tcdm_wen_o  = {MP{wen_i}};
  assign tcdm_be_o   = be_i;
  assign tcdm_data_o = data_i;

  // Port responses only belong to a counted read; stray ones after a clear are dropped.
  assign rsp_ok = (cnt_q != '0);

  for (genvar g = 0; g < MP; g++) begin : g_port
    assign tcdm_add_o[g*AW +: AW] = add_i + AW'(g * NB);

    redmule_tcdm_rsp_fifo #(
      .Depth (OUTST),
      .Width (NW)
    ) i_rsp_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (clear_i),
      .push_i  (tcdm_r_valid_i[g] & rsp_ok),
      .data_i  (tcdm_r_data_i[g*NW +: NW]),
      .pop_i   (r_valid_o),
      .data_o  (heads[g*NW +: NW]),
      .empty_o (fifo_empty[g]),
      .full_o  (fifo_full[g])
    );
  end

  assign r_valid_o = &(~fifo_empty);
  assign r_data_o  = r_valid_o ? heads : '0;
  assign busy_o    = (|granted_q) | (cnt_q != '0);

  always_comb begin
    granted_d = granted_q | hit;
    if (gnt_o) granted_d = '0;
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({gnt_o & wen_i, r_valid_o})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      granted_q <= '0;
      cnt_q     <= '0;
    end else if (clear_i) begin
      granted_q <= '0;
      cnt_q     <= '0;
    end else begin
      granted_q <= granted_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef REDMULE_TCDM_SPLITTER_PERF_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (clear_i) begin
      stall_cnt_q <= '0;
    end else if (req_i && !gnt_o && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cycles_o = stall_cnt_q;
`endif

`ifndef SYNTHESIS
  logic            pend_q;
  logic [AW-1:0]   add_q;
  logic            wen_q;
  logic [DW/8-1:0] be_q;
  logic [DW-1:0]   data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q <= 1'b0;
      add_q  <= '0;
      wen_q  <= 1'b0;
      be_q   <= '0;
      data_q <= '0;
    end else begin
      pend_q <= req_i & ~gnt_o;
      add_q  <= add_i;
      wen_q  <= wen_i;
      be_q   <= be_i;
      data_q <= data_i;
    end
  end

  a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    pend_q |-> (req_i && add_i == add_q && wen_i == wen_q && be_i == be_q && data_i == data_q));

  a_rsp_counted: assert property (@(posedge clk_i) disable iff (rst_i)
    (|tcdm_r_valid_i) |-> (cnt_q != '0));
`endif

endmodule

// File: tb/tb_redmule_tcdm_splitter.sv
module tb_redmule_tcdm_splitter;

  localparam int DW = 128;
  localparam int MP = 4;
  localparam int AW = 32;

  logic             clk, rst, clear, req, gnt, wen, r_valid, busy;
  logic [AW-1:0]    add;
  logic [DW/8-1:0]  be, t_be;
  logic [DW-1:0]    data, r_data, t_data, t_r_data;
  logic [MP-1:0]    t_req, t_gnt, t_wen, t_r_valid;
  logic [MP*AW-1:0] t_add;
`ifdef REDMULE_TCDM_SPLITTER_PERF_EN
  logic [31:0]      stall_cycles;
`endif

  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] mon_exp;
  int n_err = 0;
  int n_chk = 0;

  redmule_tcdm_splitter dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .clear_i        (clear),
    .req_i          (req),
    .gnt_o          (gnt),
    .add_i          (add),
    .wen_i          (wen),
    .be_i           (be),
    .data_i         (data),
    .r_data_o       (r_data),
    .r_valid_o      (r_valid),
    .tcdm_req_o     (t_req),
    .tcdm_gnt_i     (t_gnt),
    .tcdm_add_o     (t_add),
    .tcdm_wen_o     (t_wen),
    .tcdm_be_o      (t_be),
    .tcdm_data_o    (t_data),
    .tcdm_r_data_i  (t_r_data),
    .tcdm_r_valid_i (t_r_valid),
`ifdef REDMULE_TCDM_SPLITTER_PERF_EN
    .stall_cycles_o (stall_cycles),
`endif
    .busy_o         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // One narrow word on port p, filler elsewhere so stray pushes would corrupt the result.
  function automatic logic [DW-1:0] slice(input int p, input logic [31:0] v);
    logic [DW-1:0] r;
    r = {MP{32'hEEEE_EEEE}};
    r[p*32 +: 32] = v;
    return r;
  endfunction

  // Scoreboard monitor: every wide response must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && r_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_rvalid: got r_valid_o=1 data %0h expected no response", r_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("r_data", r_data, mon_exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clear = 1'b0; req = 1'b0; add = '0; wen = 1'b0; be = '0; data = '0;
    t_gnt = '0; t_r_data = '0; t_r_valid = '0;

    // Reset state
    smp();
    check("rst_gnt", gnt, 0);
    check("rst_rvalid", r_valid, 0);
    check("rst_treq", t_req, 0);
    check("rst_busy", busy, 0);
    check("rst_rdata", r_data, 0);
    nxt(); rst = 1'b0;
    nxt();

    // Write, all ports grant in the request cycle
    req = 1'b1; wen = 1'b0; add = 32'h1000; be = 16'hA5F0;
    data = 128'h4444_4444_3333_3333_2222_2222_1111_1111; t_gnt = 4'hF;
    smp();
    check("wr_gnt", gnt, 1);
    check("wr_treq", t_req, 4'hF);
    check("wr_tadd", t_add, {32'h100C, 32'h1008, 32'h1004, 32'h1000});
    check("wr_tdata", t_data, 128'h4444_4444_3333_3333_2222_2222_1111_1111);
    check("wr_tbe", t_be, 16'hA5F0);
    check("wr_twen", t_wen, 4'h0);
    nxt(); req = 1'b0; t_gnt = '0;
    smp();
    check("wr_busy_after", busy, 0);

    // Read split over two grant cycles
    nxt(); req = 1'b1; wen = 1'b1; add = 32'h2000; t_gnt = 4'b0101;
    smp();
    check("rd_c0_treq", t_req, 4'b1111);
    check("rd_c0_gnt", gnt, 0);
    check("rd_c0_twen", t_wen, 4'hF);
    nxt(); t_gnt = 4'b0000;
    smp();
    check("rd_c1_treq", t_req, 4'b1010);
    check("rd_c1_gnt", gnt, 0);
    check("rd_c1_busy", busy, 1);
    nxt(); t_gnt = 4'b1010;
    smp();
    check("rd_c2_treq", t_req, 4'b1010);
    check("rd_c2_gnt", gnt, 1);
    nxt(); req = 1'b0; t_gnt = '0;
    smp();
    check("rd_post_treq", t_req, 0);
    check("rd_post_busy", busy, 1);

    // Responses arrive on ports 3,1,0,2
    nxt(); t_r_valid = 4'b1000; t_r_data = slice(3, 32'hD);
    smp(); check("rsp3_rvalid", r_valid, 0);
    nxt(); t_r_valid = 4'b0010; t_r_data = slice(1, 32'hB);
    smp(); check("rsp1_rvalid", r_valid, 0);
    nxt(); t_r_valid = 4'b0001; t_r_data = slice(0, 32'hA);
    smp(); check("rsp0_rvalid", r_valid, 0);
    nxt(); t_r_valid = 4'b0100; t_r_data = slice(2, 32'hC);
    exp_q.push_back({32'hD, 32'hC, 32'hB, 32'hA});
    smp(); check("rsp2_rvalid", r_valid, 0);
    nxt(); t_r_valid = '0;
    smp(); check("rsp_done_rvalid", r_valid, 1);
    nxt();
    smp();
    check("rsp_after_rvalid", r_valid, 0);
    check("rsp_after_busy", busy, 0);

    // Outstanding bound: third read stalls until one wide response returns
    nxt(); req = 1'b1; wen = 1'b1; add = 32'h3000; t_gnt = 4'hF;
    smp(); check("os_a_gnt", gnt, 1);
    nxt(); add = 32'h3010;
    smp(); check("os_b_gnt", gnt, 1);
    nxt(); add = 32'h3020;
    smp();
    check("os_c_treq", t_req, 0);
    check("os_c_gnt", gnt, 0);
    nxt();
    smp(); check("os_c_gnt_hold", gnt, 0);
    nxt(); t_r_valid = 4'hF; t_r_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    exp_q.push_back({32'hA3, 32'hA2, 32'hA1, 32'hA0});
    smp(); check("os_rspa_gnt", gnt, 0);
    nxt(); t_r_valid = '0;
    smp();
    check("os_popa_rvalid", r_valid, 1);
    check("os_popa_gnt", gnt, 0);
    nxt();
    smp();
    check("os_c_gnt_late", gnt, 1);
    check("os_c_treq_late", t_req, 4'hF);
    check("os_c_rvalid", r_valid, 0);
    nxt(); req = 1'b0; t_gnt = '0; t_r_valid = 4'hF; t_r_data = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    exp_q.push_back({32'hB3, 32'hB2, 32'hB1, 32'hB0});
    smp();
    nxt(); t_r_valid = 4'hF; t_r_data = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    exp_q.push_back({32'hC3, 32'hC2, 32'hC1, 32'hC0});
    smp(); check("os_popb_rvalid", r_valid, 1);
    nxt(); t_r_valid = '0;
    smp(); check("os_popc_rvalid", r_valid, 1);
    nxt();
    smp(); check("os_idle_busy", busy, 0);

    // Clear drops a partial grant; held write re-issues on every port
    nxt(); req = 1'b1; wen = 1'b0; add = 32'h5000; t_gnt = 4'b0001;
    smp();
    check("clr_c0_treq", t_req, 4'hF);
    check("clr_c0_gnt", gnt, 0);
    nxt(); t_gnt = '0; clear = 1'b1;
    smp();
    check("clr_treq", t_req, 0);
    check("clr_gnt", gnt, 0);
    nxt(); clear = 1'b0;
    smp();
    check("clr_after_busy", busy, 0);
    check("clr_after_treq", t_req, 4'hF);
    nxt(); t_gnt = 4'hF;
    smp(); check("clr_final_gnt", gnt, 1);
    nxt(); req = 1'b0; t_gnt = '0;

    // Reset mid-transaction after port 1 grants
    nxt(); req = 1'b1; wen = 1'b0; add = 32'h4000; t_gnt = 4'b0010;
    smp(); check("rm_c0_gnt", gnt, 0);
    nxt(); t_gnt = '0;
    smp();
    check("rm_c1_treq", t_req, 4'b1101);
    check("rm_c1_busy", busy, 1);
    nxt(); rst = 1'b1;
    smp();
    check("rm_rst_gnt", gnt, 0);
    check("rm_rst_treq", t_req, 0);
    check("rm_rst_busy", busy, 0);
    check("rm_rst_rvalid", r_valid, 0);
    check("rm_rst_rdata", r_data, 0);
    nxt(); rst = 1'b0;
    smp();
    check("rm_reissue_treq", t_req, 4'hF);
    check("rm_reissue_busy", busy, 0);
    nxt(); t_gnt = 4'hF;
    smp(); check("rm_final_gnt", gnt, 1);
    nxt(); req = 1'b0; t_gnt = '0;

`ifdef REDMULE_TCDM_SPLITTER_PERF_EN
    clear = 1'b1;
    smp();
    nxt(); clear = 1'b0;
    smp(); check("perf_cleared", stall_cycles, 0);
    nxt(); req = 1'b1; wen = 1'b0; add = 32'h6000;
    for (int i = 0; i < 5; i++) begin
      smp();
      nxt();
    end
    t_gnt = 4'hF;
    smp();
    check("perf_gnt", gnt, 1);
    check("perf_count", stall_cycles, 5);
    nxt(); req = 1'b0; t_gnt = '0;
    smp(); check("perf_hold", stall_cycles, 5);
    nxt(); clear = 1'b1;
    smp();
    nxt(); clear = 1'b0;
    smp(); check("perf_clear", stall_cycles, 0);
`endif

    repeat (3) nxt();
    smp();
    check("sb_drained", exp_q.size(), 0);
    check("end_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
